// File: rtl/bf_sched_pkg.sv
// Shared types and default widths for the beamforming weight scheduler.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package bf_sched_pkg;

    localparam int BF_WEIGHT_WIDTH = 8;
    localparam int BF_NUM_BEAMS    = 8;
    localparam int BF_IDX_WIDTH    = $clog2(BF_NUM_BEAMS);
    localparam int BF_DWELL_WIDTH  = 16;

    // Scheduler operating states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } bf_state_e;

    // One complex weight; real part occupies the upper half of the packed word
    typedef struct packed {
        logic signed [BF_WEIGHT_WIDTH-1:0] re;
        logic signed [BF_WEIGHT_WIDTH-1:0] im;
    } cweight_t;

endpackage

// File: rtl/bf_weight_bank.sv
// Double-banked complex weight table: writes go to the shadow bank, reads from any bank.
// Latency: write lands on the next clock edge; read is combinational.
// Backpressure: none, every write strobe is accepted.
module bf_weight_bank
    import bf_sched_pkg::*;
#(
    parameter int NUM_BEAMS = BF_NUM_BEAMS,
    parameter int IDX_WIDTH = BF_IDX_WIDTH
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 active_bank,
    input  logic                 wr_en,
    input  logic [IDX_WIDTH-1:0] wr_addr,
    input  cweight_t             wr_dat,
    input  logic                 rd_bank,
    input  logic [IDX_WIDTH-1:0] rd_addr,
    output cweight_t             rd_dat
);

    cweight_t mem [2][NUM_BEAMS];

    // Shadow-bank write port; the shadow is whichever bank is not active before this edge
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int b = 0; b < 2; b++) begin
                for (int e = 0; e < NUM_BEAMS; e++) begin
                    mem[b][e] <= '0;
                end
            end
        end else if (wr_en) begin
            mem[~active_bank][wr_addr] <= wr_dat;
        end
    end

    // The scheduler reads with its next-state bank/index so the output register
    // can pick up the new weight on the same edge that moves the pointer.
    assign rd_dat = mem[rd_bank][rd_addr];

endmodule

// File: rtl/bf_weight_scheduler.sv
// Steps beamforming weights through a double-banked table on packet boundaries of a tapped AXI-stream.
// Latency: weights update on the edge closing a boundary beat; start -> weights 1 cycle; IDLE commit -> swap_done 1 cycle.
// Backpressure: none; the stream handshake is only observed, never stalled.
module bf_weight_scheduler
    import bf_sched_pkg::*;
#(
    parameter int WEIGHT_WIDTH = BF_WEIGHT_WIDTH,
    parameter int NUM_BEAMS    = BF_NUM_BEAMS,
    parameter int IDX_WIDTH    = $clog2(NUM_BEAMS),
    parameter int DWELL_WIDTH  = BF_DWELL_WIDTH
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    cfg_wr_en,
    input  logic [IDX_WIDTH-1:0]    cfg_wr_addr,
    input  logic [WEIGHT_WIDTH-1:0] cfg_wr_real,
    input  logic [WEIGHT_WIDTH-1:0] cfg_wr_imag,
    input  logic [IDX_WIDTH:0]      cfg_num_beams,
    input  logic [DWELL_WIDTH-1:0]  cfg_dwell,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    commit,
    input  logic                    mon_tvalid,
    input  logic                    mon_tready,
    input  logic                    mon_tlast,
    output logic [WEIGHT_WIDTH-1:0] bWeight_real,
    output logic [WEIGHT_WIDTH-1:0] bWeight_imag,
    output logic [IDX_WIDTH-1:0]    beam_idx,
    output logic                    busy,
    output logic                    swap_pending,
    output logic                    swap_done
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_DRAIN = DRAIN;

    logic [1:0]             state_q,   state_d;
    logic                   bank_q,    bank_d;
    logic [IDX_WIDTH-1:0]   idx_q,     idx_d;
    logic [DWELL_WIDTH-1:0] dcnt_q,    dcnt_d;
    logic [IDX_WIDTH:0]     nbeams_q,  nbeams_d;
    logic [DWELL_WIDTH-1:0] dwell_q,   dwell_d;
    logic                   in_pkt_q,  in_pkt_d;
    logic                   pend_q,    pend_d;
    logic                   swap_done_q;
    cweight_t               w_q,       w_d;

    logic                   beat;
    logic                   boundary;
    logic                   swap;
    logic                   relatch;
    logic                   last_beam;
    logic                   last_dwell;
    logic [IDX_WIDTH-1:0]   idx_adv;
    logic [IDX_WIDTH:0]     cfg_beams_eff;
    logic [DWELL_WIDTH-1:0] cfg_dwell_eff;
    cweight_t               wr_dat;
    cweight_t               rd_dat;

    assign wr_dat = cweight_t'({cfg_wr_real, cfg_wr_imag});

    bf_weight_bank #(
        .NUM_BEAMS (NUM_BEAMS),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_bank (
        .clock       (clock),
        .resetn      (resetn),
        .active_bank (bank_q),
        .wr_en       (cfg_wr_en),
        .wr_addr     (cfg_wr_addr),
        .wr_dat      (wr_dat),
        .rd_bank     (bank_d),
        .rd_addr     (idx_d),
        .rd_dat      (rd_dat)
    );

    // Stream events, packet tracking and sanitised configuration
    always_comb begin
        beat          = mon_tvalid & mon_tready;
        boundary      = beat & mon_tlast;
        in_pkt_d      = boundary ? 1'b0 : (beat ? 1'b1 : in_pkt_q);
        cfg_beams_eff = cfg_num_beams;
        if (cfg_num_beams == '0) begin
            cfg_beams_eff = (IDX_WIDTH+1)'(1);
        end else if (cfg_num_beams > (IDX_WIDTH+1)'(NUM_BEAMS)) begin
            cfg_beams_eff = (IDX_WIDTH+1)'(NUM_BEAMS);
        end
        cfg_dwell_eff = (cfg_dwell == '0) ? DWELL_WIDTH'(1) : cfg_dwell;
        last_beam     = ({1'b0, idx_q} == (nbeams_q - (IDX_WIDTH+1)'(1)));
        last_dwell    = (dcnt_q == (dwell_q - DWELL_WIDTH'(1)));
        idx_adv       = last_beam ? '0 : (idx_q + IDX_WIDTH'(1));
    end

    // Scheduler FSM: beam stepping, swap arbitration and stop/drain handling
    always_comb begin
        state_d  = state_q;
        bank_d   = bank_q;
        idx_d    = idx_q;
        dcnt_d   = dcnt_q;
        nbeams_d = nbeams_q;
        dwell_d  = dwell_q;
        pend_d   = pend_q;
        swap     = 1'b0;
        relatch  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A swap left pending by a stop/boundary collision is applied here too
                if (commit || pend_q) begin
                    swap = 1'b1;
                end
                if (start) begin
                    state_d = ST_RUN;
                    relatch = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    if (commit) begin
                        pend_d = 1'b1;
                    end
                    // Drain only if a packet is still open after this cycle's beat
                    state_d = (!boundary && in_pkt_d) ? ST_DRAIN : ST_IDLE;
                end else if (boundary) begin
                    if (pend_q) begin
                        swap   = 1'b1;
                        idx_d  = '0;
                        dcnt_d = '0;
                    end else begin
                        if (commit) begin
                            pend_d = 1'b1;
                        end
                        if (last_dwell) begin
                            dcnt_d = '0;
                            idx_d  = idx_adv;
                        end else begin
                            dcnt_d = dcnt_q + DWELL_WIDTH'(1);
                        end
                    end
                end else if (commit) begin
                    pend_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (commit) begin
                    pend_d = 1'b1;
                end
                if (boundary) begin
                    state_d = ST_IDLE;
                    if (pend_q) begin
                        swap = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A swap consumes the pending request; a same-cycle commit is a repeat and is dropped
        if (swap) begin
            bank_d  = ~bank_q;
            pend_d  = 1'b0;
            relatch = 1'b1;
        end
        if (relatch) begin
            nbeams_d = cfg_beams_eff;
            dwell_d  = cfg_dwell_eff;
        end
        if (state_d == ST_IDLE) begin
            idx_d  = '0;
            dcnt_d = '0;
        end
    end

    // Output weight: muted in IDLE, reloaded on entry to RUN and on each boundary, held otherwise
    always_comb begin
        w_d = w_q;
        if (state_d == ST_IDLE) begin
            w_d = '0;
        end else if ((state_d == ST_RUN) && ((state_q != ST_RUN) || boundary)) begin
            w_d = rd_dat;
        end
    end

    // State and output registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            bank_q      <= 1'b0;
            idx_q       <= '0;
            dcnt_q      <= '0;
            nbeams_q    <= (IDX_WIDTH+1)'(1);
            dwell_q     <= DWELL_WIDTH'(1);
            in_pkt_q    <= 1'b0;
            pend_q      <= 1'b0;
            swap_done_q <= 1'b0;
            w_q         <= '0;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            idx_q       <= idx_d;
            dcnt_q      <= dcnt_d;
            nbeams_q    <= nbeams_d;
            dwell_q     <= dwell_d;
            in_pkt_q    <= in_pkt_d;
            pend_q      <= pend_d;
            swap_done_q <= swap;
            w_q         <= w_d;
        end
    end

    assign bWeight_real = w_q.re;
    assign bWeight_imag = w_q.im;
    assign beam_idx     = idx_q;
    assign busy         = (state_q != ST_IDLE);
    assign swap_pending = pend_q;
    assign swap_done    = swap_done_q;

endmodule

// File: tb/tb_bf_weight_scheduler.sv
// Bench for bf_weight_scheduler: directed scenarios followed by randomized traffic against a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_bf_weight_scheduler;

    logic        clock;
    logic        resetn;
    logic        cfg_wr_en;
    logic [2:0]  cfg_wr_addr;
    logic [7:0]  cfg_wr_real;
    logic [7:0]  cfg_wr_imag;
    logic [3:0]  cfg_num_beams;
    logic [15:0] cfg_dwell;
    logic        start;
    logic        stop;
    logic        commit;
    logic        mon_tvalid;
    logic        mon_tready;
    logic        mon_tlast;
    logic [7:0]  bWeight_real;
    logic [7:0]  bWeight_imag;
    logic [2:0]  beam_idx;
    logic        busy;
    logic        swap_pending;
    logic        swap_done;

    int chk_cnt = 0;
    int err_cnt = 0;

    // Reference model: mode 0 idle, 1 running, 2 draining
    int         m_mode, m_ab, m_idx, m_dcnt, m_nb, m_dw, m_pend, m_inpkt, m_sd;
    logic [7:0] m_wr, m_wi;
    logic [7:0] t_re [2][8];
    logic [7:0] t_im [2][8];

    bf_weight_scheduler dut (
        .clock         (clock),
        .resetn        (resetn),
        .cfg_wr_en     (cfg_wr_en),
        .cfg_wr_addr   (cfg_wr_addr),
        .cfg_wr_real   (cfg_wr_real),
        .cfg_wr_imag   (cfg_wr_imag),
        .cfg_num_beams (cfg_num_beams),
        .cfg_dwell     (cfg_dwell),
        .start         (start),
        .stop          (stop),
        .commit        (commit),
        .mon_tvalid    (mon_tvalid),
        .mon_tready    (mon_tready),
        .mon_tlast     (mon_tlast),
        .bWeight_real  (bWeight_real),
        .bWeight_imag  (bWeight_imag),
        .beam_idx      (beam_idx),
        .busy          (busy),
        .swap_pending  (swap_pending),
        .swap_done     (swap_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_ab = 0; m_idx = 0; m_dcnt = 0; m_nb = 1; m_dw = 1;
        m_pend = 0; m_inpkt = 0; m_sd = 0; m_wr = '0; m_wi = '0;
        for (int b = 0; b < 2; b++) begin
            for (int e = 0; e < 8; e++) begin
                t_re[b][e] = '0;
                t_im[b][e] = '0;
            end
        end
    endtask

    // Advance the model by one clock edge using the inputs presented for that edge
    task automatic model_step();
        bit beat, bnd, nxt_in, load, swap;
        int wb, n;
        beat   = mon_tvalid && mon_tready;
        bnd    = beat && mon_tlast;
        nxt_in = bnd ? 1'b0 : (beat ? 1'b1 : m_inpkt[0]);
        wb     = 1 - m_ab;
        load   = 0;
        swap   = 0;
        if (m_mode == 0) begin
            swap = commit || (m_pend != 0);
            if (start) begin
                m_mode = 1;
                load   = 1;
                n = int'(cfg_num_beams);
                m_nb = (n == 0) ? 1 : ((n > 8) ? 8 : n);
                m_dw = (cfg_dwell == 0) ? 1 : int'(cfg_dwell);
            end
        end else if (m_mode == 1) begin
            if (stop) begin
                if (commit) m_pend = 1;
                m_mode = (!bnd && nxt_in) ? 2 : 0;
            end else if (bnd) begin
                load = 1;
                if (m_pend != 0) begin
                    swap = 1; m_idx = 0; m_dcnt = 0;
                end else begin
                    if (commit) m_pend = 1;
                    if (m_dcnt + 1 == m_dw) begin
                        m_dcnt = 0;
                        m_idx  = (m_idx + 1) % m_nb;
                    end else begin
                        m_dcnt = m_dcnt + 1;
                    end
                end
            end else if (commit) begin
                m_pend = 1;
            end
        end else begin
            if (bnd) begin
                m_mode = 0;
                swap   = (m_pend != 0);
            end
            if (!swap && commit) m_pend = 1;
        end
        if (swap) begin
            m_ab   = 1 - m_ab;
            m_pend = 0;
            n = int'(cfg_num_beams);
            m_nb = (n == 0) ? 1 : ((n > 8) ? 8 : n);
            m_dw = (cfg_dwell == 0) ? 1 : int'(cfg_dwell);
        end
        m_sd = swap ? 1 : 0;
        if (m_mode == 0) begin
            m_idx = 0; m_dcnt = 0; m_wr = '0; m_wi = '0;
        end else if (load) begin
            m_wr = t_re[m_ab][m_idx];
            m_wi = t_im[m_ab][m_idx];
        end
        if (cfg_wr_en) begin
            t_re[wb][cfg_wr_addr] = cfg_wr_real;
            t_im[wb][cfg_wr_addr] = cfg_wr_imag;
        end
        m_inpkt = nxt_in ? 1 : 0;
    endtask

    task automatic compare_all();
        chk("w_real",       32'(bWeight_real), 32'(m_wr));
        chk("w_imag",       32'(bWeight_imag), 32'(m_wi));
        chk("beam_idx",     32'(beam_idx),     32'(m_idx));
        chk("busy",         32'(busy),         32'(m_mode != 0));
        chk("swap_pending", 32'(swap_pending), 32'(m_pend));
        chk("swap_done",    32'(swap_done),    32'(m_sd));
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare_all();
    endtask

    task automatic idle_inputs();
        cfg_wr_en = 0; cfg_wr_addr = '0; cfg_wr_real = '0; cfg_wr_imag = '0;
        start = 0; stop = 0; commit = 0;
        mon_tvalid = 0; mon_tready = 1; mon_tlast = 0;
    endtask

    // Asynchronous reset applied between edges; outputs must clear before any clock
    task automatic do_reset();
        resetn = 1'b0;
        #1;
        chk("rst_w_real",       32'(bWeight_real), 32'd0);
        chk("rst_w_imag",       32'(bWeight_imag), 32'd0);
        chk("rst_beam_idx",     32'(beam_idx),     32'd0);
        chk("rst_busy",         32'(busy),         32'd0);
        chk("rst_swap_pending", 32'(swap_pending), 32'd0);
        chk("rst_swap_done",    32'(swap_done),    32'd0);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    initial begin
        int         seq_exp [10];
        logic [7:0] e_re, e_im, hold_re;
        seq_exp = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        idle_inputs();
        cfg_num_beams = 4'd1;
        cfg_dwell     = 16'd1;
        resetn        = 1'b1;
        @(negedge clock);
        do_reset();

        // Sequencing: fill shadow bank 1, commit in IDLE, 4 beams x 2 packets each
        for (int k = 0; k < 4; k++) begin
            cfg_wr_en   = 1;
            cfg_wr_addr = 3'(k);
            cfg_wr_real = 8'(16 * k);
            cfg_wr_imag = 8'(-16 * k);
            tick();
        end
        cfg_wr_en = 0;
        commit    = 1;
        tick();
        chk("idle_commit_swap_done", 32'(swap_done), 32'd1);
        commit        = 0;
        cfg_num_beams = 4'd4;
        cfg_dwell     = 16'd2;
        start         = 1;
        tick();
        start = 0;
        chk("start_busy", 32'(busy), 32'd1);
        for (int p = 0; p < 10; p++) begin
            mon_tvalid = 1; mon_tlast = 1;
            e_re = 8'(16 * seq_exp[p]);
            e_im = 8'(-16 * seq_exp[p]);
            chk("seq_idx",  32'(beam_idx),     32'(seq_exp[p]));
            chk("seq_real", 32'(bWeight_real), 32'(e_re));
            chk("seq_imag", 32'(bWeight_imag), 32'(e_im));
            tick();
        end
        mon_tvalid = 0; mon_tlast = 0;

        // Mid-run swap: new bank 0 entry 0, commit on beat 2 of the third 4-beat packet
        cfg_wr_en = 1; cfg_wr_addr = 3'd0; cfg_wr_real = 8'h55; cfg_wr_imag = 8'h2A;
        tick();
        cfg_wr_en = 0;
        hold_re = '0;
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < 4; b++) begin
                mon_tvalid = 1;
                mon_tlast  = (b == 3);
                commit     = (p == 2 && b == 1);
                if (p == 2 && b == 0) hold_re = m_wr;
                if (p == 2 && b >= 1) chk("swap_hold", 32'(bWeight_real), 32'(hold_re));
                tick();
            end
        end
        commit = 0; mon_tvalid = 0; mon_tlast = 0;
        chk("swap_done_pulse", 32'(swap_done),    32'd1);
        chk("swap_idx",        32'(beam_idx),     32'd0);
        chk("swap_real",       32'(bWeight_real), 32'h55);
        chk("swap_imag",       32'(bWeight_imag), 32'h2A);

        // Stop mid-packet drains; weights hold until tlast
        mon_tvalid = 1; mon_tlast = 0;
        tick();
        mon_tvalid = 0; stop = 1;
        tick();
        stop = 0;
        chk("drain_busy", 32'(busy),         32'd1);
        chk("drain_hold", 32'(bWeight_real), 32'h55);
        tick();
        tick();
        chk("drain_hold_late", 32'(bWeight_real), 32'h55);
        mon_tvalid = 1; mon_tlast = 1;
        tick();
        mon_tvalid = 0; mon_tlast = 0;
        chk("drain_exit_busy", 32'(busy),         32'd0);
        chk("drain_exit_w",    32'(bWeight_real), 32'd0);
        start = 1;
        tick();
        start = 0; stop = 1;
        tick();
        stop = 0;
        chk("stop_idle_busy", 32'(busy), 32'd0);

        // Clamps: dwell 0 behaves as 1, 12 beams behaves as 8
        cfg_dwell = 16'd0; cfg_num_beams = 4'd12; start = 1;
        tick();
        start = 0;
        for (int p = 0; p < 10; p++) begin
            mon_tvalid = 1; mon_tlast = 1;
            chk("clamp_idx", 32'(beam_idx), 32'(p % 8));
            tick();
        end
        // Stop coincident with a boundary goes straight to IDLE
        stop = 1;
        tick();
        stop = 0; mon_tvalid = 0; mon_tlast = 0;
        chk("collide_busy", 32'(busy), 32'd0);

        // Reset mid-packet, then traffic without start stays muted
        start = 1;
        tick();
        start = 0; mon_tvalid = 1; mon_tlast = 0;
        tick();
        do_reset();
        for (int b = 0; b < 5; b++) begin
            mon_tvalid = 1; mon_tlast = (b == 4);
            tick();
            chk("post_rst_w", 32'(bWeight_real), 32'd0);
        end
        idle_inputs();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            mon_tvalid    = ($urandom_range(0, 99) < 70);
            mon_tready    = ($urandom_range(0, 99) < 80);
            mon_tlast     = ($urandom_range(0, 99) < 30);
            start         = ($urandom_range(0, 99) < 6);
            stop          = ($urandom_range(0, 99) < 3);
            commit        = ($urandom_range(0, 99) < 5);
            cfg_wr_en     = ($urandom_range(0, 99) < 40);
            cfg_wr_addr   = 3'($urandom_range(0, 7));
            cfg_wr_real   = 8'($urandom_range(0, 255));
            cfg_wr_imag   = 8'($urandom_range(0, 255));
            cfg_num_beams = 4'($urandom_range(0, 15));
            cfg_dwell     = 16'($urandom_range(0, 3));
            tick();
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/bf_weight_scheduler.md
# bf_weight_scheduler

Sequences complex beamforming weights into the beamforming multiplier's `bWeight_real`/`bWeight_imag` inputs. It holds a double-banked weight table and steps through beams on packet boundaries, observed on the multiplier's input AXI-stream handshake. Every weight change lands exactly on the first beat of a packet, with no bubble. Software writes the shadow bank and commits it; the swap takes effect at the next boundary.

## Interface
- `WEIGHT_WIDTH`, 8: signed fixed-point weight width, matching the multiplier.
- `NUM_BEAMS`, 8: table depth per bank.
- `IDX_WIDTH`, 3: `$clog2(NUM_BEAMS)`.
- `DWELL_WIDTH`, 16: width of the packets-per-beam counter.
- `clock`  in  1: single clock domain.
- `resetn`  in  1: asynchronous, active-low reset.
- `cfg_wr_en`  in  1: write strobe to the shadow (inactive) bank.
- `cfg_wr_addr`  in  IDX_WIDTH: entry index.
- `cfg_wr_real` / `cfg_wr_imag`  in  WEIGHT_WIDTH: weight to write.
- `cfg_num_beams`  in  IDX_WIDTH+1: active beam count.
- `cfg_dwell`  in  DWELL_WIDTH: packets per beam.
- `start` / `stop` / `commit`  in  1: single-cycle control pulses.
- `mon_tvalid` / `mon_tready` / `mon_tlast`  in  1: taps of the multiplier's `s_axis_real` handshake.
- `bWeight_real` / `bWeight_imag`  out  WEIGHT_WIDTH: registered weights driven to the multiplier.
- `beam_idx`  out  IDX_WIDTH: current beam.
- `busy`  out  1: high in RUN or DRAIN.
- `swap_pending`  out  1: a commit is waiting for a boundary.
- `swap_done`  out  1: one-cycle pulse when the banks toggle.

## Operation
- **Events:**
  - beat = `mon_tvalid & mon_tready`.
  - boundary = beat & `mon_tlast`.
  - `in_pkt` is set on a beat without `tlast` and cleared on a boundary.
- **Banks:**
  - Two banks of `NUM_BEAMS` complex entries.
  - `active_bank` drives the outputs.
  - `cfg_wr_*` always writes bank `~active_bank`, using the pre-edge value of `active_bank`.
  - After a swap, the new shadow bank holds stale data; software rewrites it before the next commit.
- **Config latch:**
  - `cfg_num_beams` and `cfg_dwell` are latched on `start` and on every swap.
  - A value of 0 is treated as 1.
  - `num_beams > NUM_BEAMS` is clamped to `NUM_BEAMS`.
- **FSM states:** IDLE, RUN, DRAIN.
- **IDLE:**
  - Weights output 0 (mutes the channel); `beam_idx` = 0.
  - `commit` swaps on the next edge.
  - `start` → RUN with `beam_idx` = 0, `dwell_cnt` = 0, outputs = active[0].
  - `start` and `commit` in the same cycle: swap, then RUN on the new bank.
- **RUN, on a boundary:**
  - If `dwell_cnt` == dwell−1: set `dwell_cnt` = 0 and advance `beam_idx`, wrapping from num_beams−1 to 0.
  - Otherwise increment `dwell_cnt`.
  - If `swap_pending`: toggle the bank instead of advancing, set `beam_idx` = 0 and `dwell_cnt` = 0, pulse `swap_done`, relatch config.
- **RUN, on `stop`:**
  - `!in_pkt` → IDLE next cycle.
  - `in_pkt` → DRAIN.
  - `stop` coincident with a boundary → IDLE; no advance or swap takes effect.
- **DRAIN:**
  - Weights hold.
  - Boundary → IDLE, and a pending swap is applied.
  - `start` in DRAIN is ignored.
- **`commit`:** sets `swap_pending` in RUN or DRAIN. Repeated commits while pending are ignored.

## Timing
- Outputs are registered and change only on the edge ending a boundary cycle, or on the `start`/`stop`/`commit` edge in IDLE.
- A next-packet first beat at cycle T+1 after a boundary at T already sees the new weights. The multiplier samples the weight on the same cycle as the data.
- Mid-packet beats never change the weights.
- Reset values (asynchronous):
  - Outputs: all weights 0, `beam_idx` 0, `busy` 0, `swap_pending` 0, `swap_done` 0.
  - Internal: state IDLE, `active_bank` 0, both banks zeroed, counters 0, `in_pkt` 0.
- Reset mid-packet aborts immediately; the next packet after release runs with zero weights until `start`.
- Latency: `start` → weights valid 1 cycle; `commit` in IDLE → `swap_done` 1 cycle.

## Structure
- Package `bf_sched_pkg` holds:
  - the state enum `{IDLE, RUN, DRAIN}`;
  - the complex-weight struct, real/imag each `WEIGHT_WIDTH`;
  - localparams for default widths.
- Sub-module `bf_weight_bank`:
  - two banks with one synchronous write port and a combinational read port;
  - takes `active_bank`;
  - reset clears all entries.
- The top level holds the FSM, counters, `in_pkt` tracking, and output registers.

## Test plan
- **Sequencing:** write bank1 entries 0..3 = (0x10·k, −0x10·k), commit in IDLE, num_beams = 4, dwell = 2, start, then 10 single-beat packets → `beam_idx` 0,0,1,1,2,2,3,3,0,0. Each packet's beat sees the matching weights; back-to-back packets show no bubble.
- **Mid-run swap:** commit during packet 3 beat 2 of 4 → weights unchanged until that packet's `tlast`. `swap_done` follows the boundary, `beam_idx` = 0, and the weights come from the new bank.
- **Stop with drain:** stop mid-packet (`in_pkt` = 1) → DRAIN, weights hold until `tlast`, then IDLE with weights 0. Stop with `in_pkt` = 0 → IDLE in 1 cycle.
- **Clamps and collisions:**
  - `cfg_dwell` = 0 and `cfg_num_beams` = 12 → `beam_idx` advances every packet and wraps at 7.
  - `stop` and boundary in the same cycle → IDLE with no advance.
- **Reset:** assert `resetn` low mid-packet in RUN → all outputs 0 asynchronously. After release, a `tvalid` burst with no `start` leaves the weights at 0.
